// File: rtl/hr_bridge.sv
// hr_bridge: ring-to-ring bridge slice. Six independent lanes (two local,
// four global). Each lane ejects flits addressed to the other ring into its
// transfer FIFO, deflects them around the ring when that FIFO is full,
// passes everything else through, and injects the head of its own transfer
// FIFO into any free slot. One cycle of latency for every path.
//
// Handshake: FIFO_p_i is a FIFO head whose bit 143 acts as "valid"; deQ_p_o
// is the combinational pop strobe, so the FIFO pops on the same rising edge
// where the flit is captured into port_p_o. enQ_p_o is a registered push
// strobe qualifying FIFO_p_o; bfull_p_i is sampled in the cycle the
// ejection decision is made, so a full FIFO is never pushed.
module hr_bridge #(
  parameter logic [1:0] LOCAL_RING = 2'b00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] port_l0_i,
  input  logic [143:0] port_l1_i,
  input  logic [143:0] port_g0_i,
  input  logic [143:0] port_g1_i,
  input  logic [143:0] port_g2_i,
  input  logic [143:0] port_g3_i,
  output logic [143:0] port_l0_o,
  output logic [143:0] port_l1_o,
  output logic [143:0] port_g0_o,
  output logic [143:0] port_g1_o,
  output logic [143:0] port_g2_o,
  output logic [143:0] port_g3_o,
  input  logic [143:0] FIFO_l0_i,
  input  logic [143:0] FIFO_l1_i,
  input  logic [143:0] FIFO_g0_i,
  input  logic [143:0] FIFO_g1_i,
  input  logic [143:0] FIFO_g2_i,
  input  logic [143:0] FIFO_g3_i,
  output logic [143:0] FIFO_l0_o,
  output logic [143:0] FIFO_l1_o,
  output logic [143:0] FIFO_g0_o,
  output logic [143:0] FIFO_g1_o,
  output logic [143:0] FIFO_g2_o,
  output logic [143:0] FIFO_g3_o,
  input  logic         bfull_l0_i,
  input  logic         bfull_l1_i,
  input  logic         bfull_g0_i,
  input  logic         bfull_g1_i,
  input  logic         bfull_g2_i,
  input  logic         bfull_g3_i,
  output logic         enQ_l0_o,
  output logic         enQ_l1_o,
  output logic         enQ_g0_o,
  output logic         enQ_g1_o,
  output logic         enQ_g2_o,
  output logic         enQ_g3_o,
  output logic         deQ_l0_o,
  output logic         deQ_l1_o,
  output logic         deQ_g0_o,
  output logic         deQ_g1_o,
  output logic         deQ_g2_o,
  output logic         deQ_g3_o
);

  localparam int NLANE = 6;

  // Lane order everywhere: 0=l0, 1=l1, 2=g0, 3=g1, 4=g2, 5=g3.
  logic [143:0] lane_port_in  [NLANE];
  logic [143:0] lane_fifo_in  [NLANE];
  logic         lane_bfull    [NLANE];
  logic [143:0] lane_port_out [NLANE];
  logic [143:0] lane_fifo_out [NLANE];
  logic         lane_enq_out  [NLANE];
  logic         lane_deq_out  [NLANE];

  assign lane_port_in[0] = port_l0_i;
  assign lane_port_in[1] = port_l1_i;
  assign lane_port_in[2] = port_g0_i;
  assign lane_port_in[3] = port_g1_i;
  assign lane_port_in[4] = port_g2_i;
  assign lane_port_in[5] = port_g3_i;

  assign lane_fifo_in[0] = FIFO_l0_i;
  assign lane_fifo_in[1] = FIFO_l1_i;
  assign lane_fifo_in[2] = FIFO_g0_i;
  assign lane_fifo_in[3] = FIFO_g1_i;
  assign lane_fifo_in[4] = FIFO_g2_i;
  assign lane_fifo_in[5] = FIFO_g3_i;

  assign lane_bfull[0] = bfull_l0_i;
  assign lane_bfull[1] = bfull_l1_i;
  assign lane_bfull[2] = bfull_g0_i;
  assign lane_bfull[3] = bfull_g1_i;
  assign lane_bfull[4] = bfull_g2_i;
  assign lane_bfull[5] = bfull_g3_i;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    // Local lanes eject traffic leaving this ring; global lanes eject
    // traffic arriving at it. That is the only per-lane difference.
    localparam bit IS_LOCAL = (i < 2);

    logic         dest_local;
    logic         need_eject;
    logic         do_eject;
    logic         do_pass;
    logic         do_inject;
    logic [143:0] port_d, port_q;
    logic [143:0] fifo_d, fifo_q;
    logic         enq_d, enq_q;

    // Slot arbitration: eject frees the slot, a pass/deflect flit keeps it.
    always_comb begin
      dest_local = (lane_port_in[i][142:141] == LOCAL_RING);
      need_eject = lane_port_in[i][143] & (IS_LOCAL ? ~dest_local : dest_local);
      do_eject   = need_eject & ~lane_bfull[i];
      do_pass    = lane_port_in[i][143] & ~do_eject;
      do_inject  = ~do_pass & lane_fifo_in[i][143];
      port_d     = '0;
      fifo_d     = '0;
      enq_d      = do_eject;
      if (do_pass) begin
        port_d = lane_port_in[i];
      end else if (do_inject) begin
        port_d = lane_fifo_in[i];
      end
      if (do_eject) begin
        fifo_d = lane_port_in[i];
      end
    end

    // Output registers; reset clears any in-flight flits.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        port_q <= '0;
        fifo_q <= '0;
        enq_q  <= 1'b0;
      end else begin
        port_q <= port_d;
        fifo_q <= fifo_d;
        enq_q  <= enq_d;
      end
    end

    assign lane_port_out[i] = port_q;
    assign lane_fifo_out[i] = fifo_q;
    assign lane_enq_out[i]  = enq_q;
    // Pop is suppressed in reset since nothing is captured then.
    assign lane_deq_out[i]  = do_inject & ~rst;
  end

  assign port_l0_o = lane_port_out[0];
  assign port_l1_o = lane_port_out[1];
  assign port_g0_o = lane_port_out[2];
  assign port_g1_o = lane_port_out[3];
  assign port_g2_o = lane_port_out[4];
  assign port_g3_o = lane_port_out[5];

  assign FIFO_l0_o = lane_fifo_out[0];
  assign FIFO_l1_o = lane_fifo_out[1];
  assign FIFO_g0_o = lane_fifo_out[2];
  assign FIFO_g1_o = lane_fifo_out[3];
  assign FIFO_g2_o = lane_fifo_out[4];
  assign FIFO_g3_o = lane_fifo_out[5];

  assign enQ_l0_o = lane_enq_out[0];
  assign enQ_l1_o = lane_enq_out[1];
  assign enQ_g0_o = lane_enq_out[2];
  assign enQ_g1_o = lane_enq_out[3];
  assign enQ_g2_o = lane_enq_out[4];
  assign enQ_g3_o = lane_enq_out[5];

  assign deQ_l0_o = lane_deq_out[0];
  assign deQ_l1_o = lane_deq_out[1];
  assign deQ_g0_o = lane_deq_out[2];
  assign deQ_g1_o = lane_deq_out[3];
  assign deQ_g2_o = lane_deq_out[4];
  assign deQ_g3_o = lane_deq_out[5];

endmodule

// File: tb/tb_hr_bridge.sv
// tb_hr_bridge: directed and random steps against hr_bridge (LOCAL_RING=0).
module tb_hr_bridge;

  localparam int W = 289; // {port_o, FIFO_o, enQ} per lane

  logic         clk;
  logic         rst;
  logic [143:0] pi [6];
  logic [143:0] fi [6];
  logic         bf [6];
  logic [143:0] po [6];
  logic [143:0] fo [6];
  logic         enq [6];
  logic         deq [6];

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hr_bridge #(.LOCAL_RING(2'b00)) dut (
    .clk(clk), .rst(rst),
    .port_l0_i(pi[0]), .port_l1_i(pi[1]), .port_g0_i(pi[2]),
    .port_g1_i(pi[3]), .port_g2_i(pi[4]), .port_g3_i(pi[5]),
    .port_l0_o(po[0]), .port_l1_o(po[1]), .port_g0_o(po[2]),
    .port_g1_o(po[3]), .port_g2_o(po[4]), .port_g3_o(po[5]),
    .FIFO_l0_i(fi[0]), .FIFO_l1_i(fi[1]), .FIFO_g0_i(fi[2]),
    .FIFO_g1_i(fi[3]), .FIFO_g2_i(fi[4]), .FIFO_g3_i(fi[5]),
    .FIFO_l0_o(fo[0]), .FIFO_l1_o(fo[1]), .FIFO_g0_o(fo[2]),
    .FIFO_g1_o(fo[3]), .FIFO_g2_o(fo[4]), .FIFO_g3_o(fo[5]),
    .bfull_l0_i(bf[0]), .bfull_l1_i(bf[1]), .bfull_g0_i(bf[2]),
    .bfull_g1_i(bf[3]), .bfull_g2_i(bf[4]), .bfull_g3_i(bf[5]),
    .enQ_l0_o(enq[0]), .enQ_l1_o(enq[1]), .enQ_g0_o(enq[2]),
    .enQ_g1_o(enq[3]), .enQ_g2_o(enq[4]), .enQ_g3_o(enq[5]),
    .deQ_l0_o(deq[0]), .deQ_l1_o(deq[1]), .deQ_g0_o(deq[2]),
    .deQ_g1_o(deq[3]), .deQ_g2_o(deq[4]), .deQ_g3_o(deq[5])
  );

  // ---------------- helpers ----------------
  function automatic logic [143:0] mk(input logic v, input logic [1:0] dest,
                                      input logic [140:0] payload);
    return {v, dest, payload};
  endfunction

  function automatic logic [140:0] rnd_payload();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference behaviour of one lane with the local ring fixed at 0.
  task automatic lane_model(input int idx, input logic [143:0] p_in,
                            input logic [143:0] f_in, input logic full,
                            output logic [W-1:0] exp_regs, output logic exp_deq);
    logic wants_out;
    logic ejected;
    logic slot_free;
    logic [143:0] e_port;
    logic [143:0] e_fifo;
    if (!p_in[143])      wants_out = 1'b0;
    else if (idx < 2)    wants_out = (p_in[142:141] != 2'd0);
    else                 wants_out = (p_in[142:141] == 2'd0);
    ejected   = wants_out && !full;
    slot_free = !p_in[143] || ejected;
    e_fifo    = ejected ? p_in : 144'h0;
    e_port    = 144'h0;
    if (!slot_free)       e_port = p_in;
    else if (f_in[143])   e_port = f_in;
    exp_deq   = slot_free && f_in[143];
    exp_regs  = {e_port, e_fifo, ejected};
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr();
    for (int i = 0; i < 6; i++) begin
      pi[i] = '0;
      fi[i] = '0;
      bf[i] = 1'b0;
    end
  endtask

  // One clock of traffic: check pops, push expectations, clock, pop/compare.
  task automatic step(input string tag);
    logic [W-1:0] e;
    logic         ed;
    #1;
    for (int i = 0; i < 6; i++) begin
      lane_model(i, pi[i], fi[i], bf[i], e, ed);
      chk($sformatf("%s.deq%0d", tag, i), W'(deq[i]), W'(ed));
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s.lane%0d", tag, i), {po[i], fo[i], enq[i]}, e);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s.regs%0d", tag, i), {po[i], fo[i], enq[i]}, '0);
      chk($sformatf("%s.deq%0d", tag, i), W'(deq[i]), '0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) fi[i] = mk(1'b1, 2'd1, 141'd3);
    #1;
    chk_all_zero("reset");
    clr();
    rst = 1'b0;

    // Idle for two clocks
    step("idle0");
    step("idle1");
    chk_all_zero("idle");

    // Pass on l0: dest is the local ring
    clr();
    pi[0] = mk(1'b1, 2'd0, 141'd5);
    step("pass_l0");
    chk("pass_l0.port", W'(po[0]), W'(mk(1'b1, 2'd0, 141'd5)));
    chk("pass_l0.enq", W'(enq[0]), '0);

    // Eject + inject on g2
    clr();
    pi[4] = mk(1'b1, 2'd0, 141'd7);
    fi[4] = mk(1'b1, 2'd1, 141'd9);
    #1;
    chk("ej_inj_g2.deq", W'(deq[4]), W'(1'b1));
    step("ej_inj_g2");
    chk("ej_inj_g2.fifo", W'(fo[4]), W'(mk(1'b1, 2'd0, 141'd7)));
    chk("ej_inj_g2.enq", W'(enq[4]), W'(1'b1));
    chk("ej_inj_g2.port", W'(po[4]), W'(mk(1'b1, 2'd1, 141'd9)));

    // Deflect on l1 with a waiting FIFO head
    clr();
    pi[1] = mk(1'b1, 2'd3, 141'd11);
    bf[1] = 1'b1;
    fi[1] = mk(1'b1, 2'd2, 141'd12);
    #1;
    chk("defl_l1.deq", W'(deq[1]), '0);
    step("defl_l1");
    chk("defl_l1.port", W'(po[1]), W'(mk(1'b1, 2'd3, 141'd11)));
    chk("defl_l1.enq", W'(enq[1]), '0);

    // Empty-slot inject on g0
    clr();
    fi[2] = mk(1'b1, 2'd2, 141'd13);
    #1;
    chk("inj_g0.deq", W'(deq[2]), W'(1'b1));
    step("inj_g0");
    chk("inj_g0.port", W'(po[2]), W'(mk(1'b1, 2'd2, 141'd13)));

    // Local eject on l0, global pass on g1, invalid FIFO head ignored on g3
    clr();
    pi[0] = mk(1'b1, 2'd2, 141'd21);
    pi[3] = mk(1'b1, 2'd1, 141'd22);
    fi[5] = mk(1'b0, 2'd0, 141'd23);
    step("mixed");
    chk("mixed.l0_fifo", W'(fo[0]), W'(mk(1'b1, 2'd2, 141'd21)));
    chk("mixed.g1_port", W'(po[3]), W'(mk(1'b1, 2'd1, 141'd22)));
    chk("mixed.g3_port", W'(po[5]), '0);

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 6; i++) begin
        pi[i] = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_payload());
        fi[i] = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_payload());
        bf[i] = 1'($urandom_range(0, 1));
      end
      step($sformatf("rnd%0d", n));
    end

    // Reset mid-traffic: flits registered, then async reset
    clr();
    for (int i = 0; i < 6; i++) begin
      pi[i] = mk(1'b1, 2'(i % 4), 141'(100 + i));
      fi[i] = mk(1'b1, 2'd1, 141'(200 + i));
    end
    step("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Resume after reset
    clr();
    pi[2] = mk(1'b1, 2'd3, 141'd31);
    fi[0] = mk(1'b1, 2'd2, 141'd32);
    step("resume");
    chk("resume.g0_port", W'(po[2]), W'(mk(1'b1, 2'd3, 141'd31)));
    chk("resume.l0_port", W'(po[0]), W'(mk(1'b1, 2'd2, 141'd32)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
